// File: rtl/data_mem_responder.sv
// Serves MEM-stage load/store requests against a 16-bit asynchronous SRAM.
// Each 32-bit access runs as two halfword phases, low half first.
module data_mem_responder #(
  parameter logic [31:0] ADDR_BASE   = 32'd1024,
  parameter int          SRAM_AW     = 18,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               MEM_R_EN_in,
  input  logic               MEM_W_EN_in,
  input  logic [31:0]        ALU_result_in,
  input  logic [31:0]        ST_val,
  output logic [31:0]        Mem_read_value,
  output logic               ready,
  output logic               addr_err,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [1:0]         dbg_state
);

  // Handshake: a request (MEM_R_EN_in or MEM_W_EN_in) is held stable by the
  // pipeline until ready pulses for one cycle; a request still high in the
  // cycle after ready starts a new access.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] LAST_WAIT = 4'(WAIT_CYCLES - 1);

  state_t             state, state_nxt;
  logic [3:0]         wait_cnt;
  logic               is_store;
  logic               err;
  logic [SRAM_AW-2:0] word_q;
  logic [31:0]        st_q;
  logic [15:0]        lo_q;

  logic        req;
  logic        req_err;
  logic        phase_end;
  logic [31:0] offset;
  logic [31:0] word_full;

  assign req       = MEM_R_EN_in | MEM_W_EN_in;
  assign offset    = ALU_result_in - ADDR_BASE;
  assign word_full = offset >> 2;
  assign req_err   = (ALU_result_in < ADDR_BASE) | (|word_full[31:SRAM_AW-1]);
  assign phase_end = (wait_cnt == LAST_WAIT);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      wait_cnt       <= 4'd0;
      is_store       <= 1'b0;
      err            <= 1'b0;
      word_q         <= '0;
      st_q           <= 32'd0;
      lo_q           <= 16'd0;
      Mem_read_value <= 32'd0;
    end else begin
      state <= state_nxt;
      if ((state == LO || state == HI) && !phase_end)
        wait_cnt <= wait_cnt + 4'd1;
      else
        wait_cnt <= 4'd0;

      if (state == IDLE && req) begin
        is_store <= MEM_W_EN_in;
        err      <= req_err;
        word_q   <= word_full[SRAM_AW-2:0];
        st_q     <= ST_val;
        // An out-of-range load completes with zero data.
        if (!MEM_W_EN_in && req_err)
          Mem_read_value <= 32'd0;
      end

      if (state == LO && phase_end && !is_store)
        lo_q <= sram_dq_in;
      if (state == HI && phase_end && !is_store)
        Mem_read_value <= {sram_dq_in, lo_q};
    end
  end

  always_comb begin
    state_nxt   = state;
    ready       = 1'b0;
    addr_err    = 1'b0;
    sram_addr   = '0;
    sram_dq_out = 16'd0;
    sram_dq_oe  = 1'b0;
    sram_ce_n   = 1'b1;
    sram_oe_n   = 1'b1;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: begin
        if (req)
          state_nxt = req_err ? DONE : LO;
      end
      LO: begin
        sram_ce_n = 1'b0;
        sram_addr = {word_q, 1'b0};
        if (is_store) begin
          sram_we_n   = 1'b0;
          sram_dq_oe  = 1'b1;
          sram_dq_out = st_q[15:0];
        end else begin
          sram_oe_n = 1'b0;
        end
        if (phase_end)
          state_nxt = HI;
      end
      HI: begin
        sram_ce_n = 1'b0;
        sram_addr = {word_q, 1'b1};
        if (is_store) begin
          sram_dq_out = st_q[31:16];
          // First HI cycle is a write-strobe gap between the two halves.
          if (wait_cnt != 4'd0) begin
            sram_we_n  = 1'b0;
            sram_dq_oe = 1'b1;
          end
        end else begin
          sram_oe_n = 1'b0;
        end
        if (phase_end)
          state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        addr_err  = err;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: one instance at WAIT_CYCLES=2, one at 1,
// each with a small SRAM model and a queue-based response scoreboard.
module tb_data_mem_responder;

  localparam int W = 49; // {read_value[31:0], addr_err, due_cycle[15:0]}

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- DUT A (WAIT_CYCLES = 2) ----------------
  logic        a_rst, a_rd, a_wr;
  logic [31:0] a_addr, a_st, a_rv;
  logic        a_ready, a_err;
  logic [17:0] a_sram_addr;
  logic [15:0] a_dq_out, a_dq_in;
  logic        a_dq_oe, a_ce_n, a_oe_n, a_we_n;
  logic [1:0]  a_state;

  data_mem_responder #(.ADDR_BASE(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst(a_rst), .MEM_R_EN_in(a_rd), .MEM_W_EN_in(a_wr),
    .ALU_result_in(a_addr), .ST_val(a_st), .Mem_read_value(a_rv),
    .ready(a_ready), .addr_err(a_err), .sram_addr(a_sram_addr),
    .sram_dq_out(a_dq_out), .sram_dq_oe(a_dq_oe), .sram_dq_in(a_dq_in),
    .sram_ce_n(a_ce_n), .sram_oe_n(a_oe_n), .sram_we_n(a_we_n),
    .dbg_state(a_state)
  );

  // ---------------- DUT B (WAIT_CYCLES = 1) ----------------
  logic        b_rst, b_rd, b_wr;
  logic [31:0] b_addr, b_st, b_rv;
  logic        b_ready, b_err;
  logic [17:0] b_sram_addr;
  logic [15:0] b_dq_out, b_dq_in;
  logic        b_dq_oe, b_ce_n, b_oe_n, b_we_n;
  logic [1:0]  b_state;

  data_mem_responder #(.ADDR_BASE(32'd1024), .SRAM_AW(18), .WAIT_CYCLES(1)) dut_b (
    .clk(clk), .rst(b_rst), .MEM_R_EN_in(b_rd), .MEM_W_EN_in(b_wr),
    .ALU_result_in(b_addr), .ST_val(b_st), .Mem_read_value(b_rv),
    .ready(b_ready), .addr_err(b_err), .sram_addr(b_sram_addr),
    .sram_dq_out(b_dq_out), .sram_dq_oe(b_dq_oe), .sram_dq_in(b_dq_in),
    .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
    .dbg_state(b_state)
  );

  // ---------------- SRAM models ----------------
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic        pl_a_en = 1'b0, pl_b_en = 1'b0;
  logic [7:0]  pl_addr = 8'd0;
  logic [15:0] pl_data = 16'd0;

  always @(posedge clk) begin
    if (pl_a_en) mem_a[pl_addr] <= pl_data;
    else if (!a_ce_n && !a_we_n && a_dq_oe) mem_a[a_sram_addr[7:0]] <= a_dq_out;
    if (pl_b_en) mem_b[pl_addr] <= pl_data;
    else if (!b_ce_n && !b_we_n && b_dq_oe) mem_b[b_sram_addr[7:0]] <= b_dq_out;
  end

  assign a_dq_in = (!a_ce_n && !a_oe_n) ? mem_a[a_sram_addr[7:0]] : 16'h0000;
  assign b_dq_in = (!b_ce_n && !b_oe_n) ? mem_b[b_sram_addr[7:0]] : 16'h0000;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_qa[$];
  logic [W-1:0] exp_qb[$];
  logic [W-1:0] ea, eb;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (a_rst === 1'b1 && a_ready === 1'b1) begin
      if (exp_qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL a_unexpected_ready actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        ea = exp_qa.pop_front();
        check32("a_read_value", a_rv, ea[48:17]);
        check32("a_addr_err", {31'd0, a_err}, {31'd0, ea[16]});
        check32("a_ready_cycle", 32'(cyc[15:0]), {16'd0, ea[15:0]});
      end
    end
  end

  always @(negedge clk) begin
    if (b_rst === 1'b1 && b_ready === 1'b1) begin
      if (exp_qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL b_unexpected_ready actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        eb = exp_qb.pop_front();
        check32("b_read_value", b_rv, eb[48:17]);
        check32("b_addr_err", {31'd0, b_err}, {31'd0, eb[16]});
        check32("b_ready_cycle", 32'(cyc[15:0]), {16'd0, eb[15:0]});
      end
    end
  end

  // ---------------- strobe monitors ----------------
  int   a_ce_count = 0, a_we_count = 0;
  logic a_prev_ce_lo = 1'b0, a_prev_lsb = 1'b0;

  always @(negedge clk) begin
    if (a_rst === 1'b1) begin
      check32("a_oe_we_exclusive", {31'd0, (!a_oe_n && !a_we_n)}, 32'd0);
      check32("b_oe_we_exclusive", {31'd0, (!b_oe_n && !b_we_n)}, 32'd0);
      if (!a_ce_n) a_ce_count++;
      if (!a_we_n) a_we_count++;
      if (a_prev_ce_lo && !a_ce_n && !a_prev_lsb && a_sram_addr[0])
        check32("a_we_gap_first_hi", {31'd0, a_we_n}, 32'd1);
      a_prev_ce_lo = !a_ce_n;
      a_prev_lsb   = a_sram_addr[0];
    end
  end

  // ---------------- drivers ----------------
  task automatic preload(input logic sel_b, input logic [7:0] adr, input logic [15:0] dat);
    @(posedge clk); #1;
    pl_addr = adr; pl_data = dat;
    if (sel_b) pl_b_en = 1'b1; else pl_a_en = 1'b1;
    @(posedge clk); #1;
    pl_a_en = 1'b0; pl_b_en = 1'b0;
  endtask

  task automatic wait_ready_a(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (a_ready) break;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ready expected=ready", name);
    end
  endtask

  task automatic wait_ready_b(input string name);
    int n;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (b_ready) break;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL %s_timeout actual=no_ready expected=ready", name);
    end
  endtask

  task automatic access_a(input string name, input logic wr, input logic rd,
                          input logic [31:0] adr, input logic [31:0] st,
                          input logic [31:0] exp_val, input logic exp_err, input int lat);
    @(posedge clk); #1;
    a_wr = wr; a_rd = rd; a_addr = adr; a_st = st;
    exp_qa.push_back({exp_val, exp_err, 16'(cyc + lat)});
    wait_ready_a(name);
    @(posedge clk); #1;
    a_wr = 1'b0; a_rd = 1'b0;
  endtask

  initial begin
    int ce_before, we_before, n;
    a_rst = 1'b0; a_rd = 1'b0; a_wr = 1'b0; a_addr = 32'd0; a_st = 32'd0;
    b_rst = 1'b0; b_rd = 1'b0; b_wr = 1'b0; b_addr = 32'd0; b_st = 32'd0;

    preload(1'b0, 8'd2, 16'hAAAA);
    preload(1'b0, 8'd3, 16'hFFFF);
    preload(1'b0, 8'd6, 16'h1234);
    preload(1'b0, 8'd7, 16'h5678);
    preload(1'b1, 8'd0, 16'h1111);
    preload(1'b1, 8'd1, 16'h2222);

    // Reset state
    @(posedge clk); #1;
    check32("rst_read_value", a_rv, 32'd0);
    check32("rst_ready", {31'd0, a_ready}, 32'd0);
    check32("rst_addr_err", {31'd0, a_err}, 32'd0);
    check32("rst_sram_addr", {14'd0, a_sram_addr}, 32'd0);
    check32("rst_dq_out_oe", {15'd0, a_dq_out, a_dq_oe}, 32'd0);
    check32("rst_strobes", {29'd0, a_ce_n, a_oe_n, a_we_n}, 32'd7);
    check32("rst_state", {30'd0, a_state}, 32'd0);
    check32("rst_b_read_value", b_rv, 32'd0);
    a_rst = 1'b1; b_rst = 1'b1;

    // Store/load round trip
    access_a("store_1024", 1'b1, 1'b0, 32'd1024, 32'hDEADBEEF, 32'd0, 1'b0, 5);
    check32("sram_hw0", {16'd0, mem_a[0]}, 32'h0000BEEF);
    check32("sram_hw1", {16'd0, mem_a[1]}, 32'h0000DEAD);
    access_a("load_1024", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0, 5);

    // Address map: word 3 -> halfwords 6 and 7
    access_a("load_1036", 1'b0, 1'b1, 32'd1036, 32'd0, 32'h56781234, 1'b0, 5);

    // Simultaneous read+write: store wins, read value unchanged
    access_a("both_1028", 1'b1, 1'b1, 32'd1028, 32'h000000FF, 32'h56781234, 1'b0, 5);
    check32("sram_hw2", {16'd0, mem_a[2]}, 32'h000000FF);
    check32("sram_hw3", {16'd0, mem_a[3]}, 32'h00000000);

    // Out of range
    ce_before = a_ce_count;
    access_a("load_1020", 1'b0, 1'b1, 32'd1020, 32'd0, 32'd0, 1'b1, 1);
    check32("err_load_no_ce", 32'(a_ce_count - ce_before), 32'd0);
    we_before = a_we_count;
    access_a("store_high", 1'b1, 1'b0, 32'd1024 + 32'h80000, 32'h12345678, 32'd0, 1'b1, 1);
    check32("err_store_no_we", 32'(a_we_count - we_before), 32'd0);

    access_a("load_1024_again", 1'b0, 1'b1, 32'd1024, 32'd0, 32'hDEADBEEF, 1'b0, 5);

    // Reset during HI of a store
    @(posedge clk); #1;
    a_wr = 1'b1; a_addr = 32'd1032; a_st = 32'hAAAA5555;
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (!a_ce_n && a_sram_addr[0]) break;
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL rst_mid_hi_timeout actual=no_hi expected=hi");
    end
    a_rst = 1'b0;
    @(posedge clk); #1;
    check32("rst_mid_strobes", {30'd0, a_ce_n, a_we_n}, 32'd3);
    check32("rst_mid_ready", {31'd0, a_ready}, 32'd0);
    check32("rst_mid_read_value", a_rv, 32'd0);
    a_wr = 1'b0;
    @(posedge clk); #1;
    a_rst = 1'b1;
    repeat (8) @(posedge clk);

    // WAIT_CYCLES=1, back-to-back loads held high
    @(posedge clk); #1;
    b_rd = 1'b1; b_addr = 32'd1024;
    exp_qb.push_back({32'h22221111, 1'b0, 16'(cyc + 3)});
    exp_qb.push_back({32'h22221111, 1'b0, 16'(cyc + 7)});
    wait_ready_b("b2b_first");
    wait_ready_b("b2b_second");
    @(posedge clk); #1;
    b_rd = 1'b0;

    repeat (5) @(posedge clk);
    check32("a_queue_drained", 32'(exp_qa.size()), 32'd0);
    check32("b_queue_drained", 32'(exp_qb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
